// File: rtl/apb_master_param_if.sv
// Command, response and APB4 bus signals of apb_master_param.
// The master modport is the requester's view. The slave modport is the view of the command source and completer.
interface apb_master_param_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  pready, prdata, pslverr,
    output cmd_ready,
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output pready, prdata, pslverr,
    input  cmd_ready,
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_master_param.sv
// Parametrised APB4 requester. It converts valid/ready commands into SETUP/ACCESS transfers.
// Each transfer returns a registered one-cycle response. A wait-state timeout can abort a transfer.
module apb_master_param #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic               pclk,
  input  logic               preset_n,
  apb_master_param_if.master bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic                 TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST  = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_WIDTH-1:0]  wait_cnt;

  logic                  hold_write;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic [STRB_WIDTH-1:0] hold_strb;
  logic [2:0]            hold_prot;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;

  logic                  in_access;
  logic                  bus_active;
  logic                  timeout_hit;
  logic                  done;
  logic                  ready;
  logic                  accept;

  // cmd_ready is gated by preset_n so that it reads 0 while reset is held.
  always_comb begin
    in_access   = (state == ST_ACCESS);
    bus_active  = (state == ST_SETUP) || in_access;
    timeout_hit = TIMEOUT_EN && in_access && !bus.pready && (wait_cnt == WAIT_LAST);
    done        = in_access && (bus.pready || timeout_hit);
    ready       = preset_n && ((state == ST_IDLE) || done);
    accept      = bus.cmd_valid && ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (done) state_nxt = bus.cmd_valid ? ST_SETUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every entry to SETUP is an acceptance, so the counter clears on accept.
  // The counter saturates, which keeps it harmless when TIMEOUT is 0.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (in_access && !bus.pready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_strb  <= '0;
      hold_prot  <= '0;
    end else if (accept) begin
      hold_write <= bus.cmd_write;
      hold_addr  <= bus.cmd_addr;
      hold_wdata <= bus.cmd_wdata;
      hold_strb  <= bus.cmd_strb;
      hold_prot  <= bus.cmd_prot;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= done;
      if (done) begin
        rsp_rdata_q   <= (!hold_write && bus.pready) ? bus.prdata : '0;
        rsp_err_q     <= bus.pready ? bus.pslverr : 1'b1;
        rsp_timeout_q <= timeout_hit;
      end
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.psel        = bus_active;
  assign bus.penable     = in_access;
  assign bus.paddr       = bus_active ? hold_addr : '0;
  assign bus.pwrite      = bus_active && hold_write;
  assign bus.pwdata      = bus_active ? hold_wdata : '0;
  assign bus.pstrb       = (bus_active && hold_write) ? hold_strb : '0;
  assign bus.pprot       = bus_active ? hold_prot : '0;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_param.sv
// Directed bench for apb_master_param with TIMEOUT=4.
// Inputs are driven and outputs are compared just after each falling edge.
module tb_apb_master_param;

  logic pclk;
  logic preset_n;
  int unsigned n_cmp;
  int unsigned n_err;

  apb_master_param_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_master_param #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TIMEOUT   (4),
    .CNT_WIDTH (8)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        valid;
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        e_psel;
    logic        e_pen;
    logic        e_rdy;
    logic [7:0]  e_addr;
    logic        e_pwrite;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [2:0] p, input logic rdy,
                       input logic [31:0] rd, input logic err);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
    bus.pready    = rdy;
    bus.prdata    = rd;
    bus.pslverr   = err;
    #1;
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".psel"},        32'(bus.psel),        32'd0);
    check({tag, ".penable"},     32'(bus.penable),     32'd0);
    check({tag, ".cmd_ready"},   32'(bus.cmd_ready),   32'd0);
    check({tag, ".paddr"},       32'(bus.paddr),       32'd0);
    check({tag, ".pwrite"},      32'(bus.pwrite),      32'd0);
    check({tag, ".pwdata"},      bus.pwdata,           32'd0);
    check({tag, ".pstrb"},       32'(bus.pstrb),       32'd0);
    check({tag, ".pprot"},       32'(bus.pprot),       32'd0);
    check({tag, ".rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    check({tag, ".rsp_rdata"},   bus.rsp_rdata,        32'd0);
    check({tag, ".rsp_err"},     32'(bus.rsp_err),     32'd0);
    check({tag, ".rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Fields: inputs (valid write addr wdata strb prot pready prdata pslverr),
    // then the expected bus (psel pen rdy addr pwrite wdata strb prot) and response (rv rdata err to).
    vecs[0]  = '{1,1,8'h10,32'hA5A5_0001,4'hF,3'd2, 0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           0,32'h0,0,0};
    vecs[1]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         1,0,0,8'h10,1,32'hA5A5_0001,4'hF,3'd2,   0,32'h0,0,0};
    vecs[2]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         1,32'h0,0,         1,1,1,8'h10,1,32'hA5A5_0001,4'hF,3'd2,   0,32'h0,0,0};
    vecs[3]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           1,32'h0,0,0};
    vecs[4]  = '{1,0,8'h24,32'h1234_5678,4'hF,3'd0, 0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           0,32'h0,0,0};
    vecs[5]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         1,0,0,8'h24,0,32'h1234_5678,4'h0,3'd0,   0,32'h0,0,0};
    vecs[6]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'hBAD0_BAD0,0, 1,1,0,8'h24,0,32'h1234_5678,4'h0,3'd0,   0,32'h0,0,0};
    vecs[7]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,1,         1,1,0,8'h24,0,32'h1234_5678,4'h0,3'd0,   0,32'h0,0,0};
    vecs[8]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         1,1,0,8'h24,0,32'h1234_5678,4'h0,3'd0,   0,32'h0,0,0};
    vecs[9]  = '{0,0,8'h00,32'h0,4'h0,3'd0,         1,32'hDEAD_BEEF,0, 1,1,1,8'h24,0,32'h1234_5678,4'h0,3'd0,   0,32'h0,0,0};
    vecs[10] = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           1,32'hDEAD_BEEF,0,0};
    vecs[11] = '{1,1,8'h30,32'h0000_00FF,4'h3,3'd5, 0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           0,32'hDEAD_BEEF,0,0};
    vecs[12] = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         1,0,0,8'h30,1,32'h0000_00FF,4'h3,3'd5,   0,32'hDEAD_BEEF,0,0};
    vecs[13] = '{0,0,8'h00,32'h0,4'h0,3'd0,         1,32'hFFFF_FFFF,1, 1,1,1,8'h30,1,32'h0000_00FF,4'h3,3'd5,   0,32'hDEAD_BEEF,0,0};
    vecs[14] = '{1,1,8'h34,32'h0000_0011,4'h1,3'd0, 0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           1,32'h0,1,0};
    vecs[15] = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         1,0,0,8'h34,1,32'h0000_0011,4'h1,3'd0,   0,32'h0,1,0};
    vecs[16] = '{0,0,8'h00,32'h0,4'h0,3'd0,         1,32'h0,0,         1,1,1,8'h34,1,32'h0000_0011,4'h1,3'd0,   0,32'h0,1,0};
    vecs[17] = '{1,1,8'h40,32'h0000_000A,4'hF,3'd1, 0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           1,32'h0,0,0};
    vecs[18] = '{1,0,8'h44,32'h0000_000B,4'hF,3'd0, 0,32'h0,0,         1,0,0,8'h40,1,32'h0000_000A,4'hF,3'd1,   0,32'h0,0,0};
    vecs[19] = '{1,0,8'h44,32'h0000_000B,4'hF,3'd0, 1,32'h0000_0055,0, 1,1,1,8'h40,1,32'h0000_000A,4'hF,3'd1,   0,32'h0,0,0};
    vecs[20] = '{1,1,8'h48,32'h0000_000C,4'hC,3'd6, 0,32'h0,0,         1,0,0,8'h44,0,32'h0000_000B,4'h0,3'd0,   1,32'h0,0,0};
    vecs[21] = '{1,1,8'h48,32'h0000_000C,4'hC,3'd6, 1,32'hCAFE_0044,0, 1,1,1,8'h44,0,32'h0000_000B,4'h0,3'd0,   0,32'h0,0,0};
    vecs[22] = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         1,0,0,8'h48,1,32'h0000_000C,4'hC,3'd6,   1,32'hCAFE_0044,0,0};
    vecs[23] = '{0,0,8'h00,32'h0,4'h0,3'd0,         1,32'h0000_0077,0, 1,1,1,8'h48,1,32'h0000_000C,4'hC,3'd6,   0,32'hCAFE_0044,0,0};
    vecs[24] = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           1,32'h0,0,0};
    vecs[25] = '{0,0,8'h00,32'h0,4'h0,3'd0,         0,32'h0,0,         0,0,1,8'h00,0,32'h0,4'h0,3'd0,           0,32'h0,0,0};

    preset_n = 1'b0;
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    check_all_zero("reset");
    tick();
    tick();
    preset_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
            vecs[i].pready, vecs[i].prdata, vecs[i].pslverr);
      check($sformatf("r%0d.psel", i),        32'(bus.psel),        32'(vecs[i].e_psel));
      check($sformatf("r%0d.penable", i),     32'(bus.penable),     32'(vecs[i].e_pen));
      check($sformatf("r%0d.cmd_ready", i),   32'(bus.cmd_ready),   32'(vecs[i].e_rdy));
      check($sformatf("r%0d.paddr", i),       32'(bus.paddr),       32'(vecs[i].e_addr));
      check($sformatf("r%0d.pwrite", i),      32'(bus.pwrite),      32'(vecs[i].e_pwrite));
      check($sformatf("r%0d.pwdata", i),      bus.pwdata,           vecs[i].e_wdata);
      check($sformatf("r%0d.pstrb", i),       32'(bus.pstrb),       32'(vecs[i].e_strb));
      check($sformatf("r%0d.pprot", i),       32'(bus.pprot),       32'(vecs[i].e_prot));
      check($sformatf("r%0d.rsp_valid", i),   32'(bus.rsp_valid),   32'(vecs[i].e_rv));
      check($sformatf("r%0d.rsp_rdata", i),   bus.rsp_rdata,        vecs[i].e_rdata);
      check($sformatf("r%0d.rsp_err", i),     32'(bus.rsp_err),     32'(vecs[i].e_err));
      check($sformatf("r%0d.rsp_timeout", i), 32'(bus.rsp_timeout), 32'(vecs[i].e_to));
      tick();
    end

    // With pready stuck low, the transfer aborts after exactly four ACCESS cycles.
    drive(1, 0, 8'h50, 32'h0, 4'hF, 3'd0, 0, 32'h0, 0);
    check("to1.idle_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h9999_9999, 1);
    check("to1.setup_psel", 32'(bus.psel), 32'd1);
    check("to1.setup_pen", 32'(bus.penable), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("to1.acc%0d_psel", k), 32'(bus.psel), 32'd1);
      check($sformatf("to1.acc%0d_pen", k), 32'(bus.penable), 32'd1);
      check($sformatf("to1.acc%0d_ready", k), 32'(bus.cmd_ready), (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("to1.acc%0d_paddr", k), 32'(bus.paddr), 32'h50);
      tick();
    end
    #1;
    check("to1.end_psel", 32'(bus.psel), 32'd0);
    check("to1.rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("to1.rsp_err", 32'(bus.rsp_err), 32'd1);
    check("to1.rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    check("to1.rsp_rdata", bus.rsp_rdata, 32'd0);
    tick();
    #1;
    check("to1.pulse_end", 32'(bus.rsp_valid), 32'd0);
    check("to1.timeout_hold", 32'(bus.rsp_timeout), 32'd1);

    // pready rising in the fourth ACCESS cycle is a normal completion.
    drive(1, 0, 8'h54, 32'h0, 4'hF, 3'd0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("to2.acc%0d_ready", k), 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 1, 32'h4444_AAAA, 0);
    check("to2.acc3_pen", 32'(bus.penable), 32'd1);
    check("to2.acc3_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    check("to2.end_psel", 32'(bus.psel), 32'd0);
    check("to2.rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("to2.rsp_err", 32'(bus.rsp_err), 32'd0);
    check("to2.rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("to2.rsp_rdata", bus.rsp_rdata, 32'h4444_AAAA);
    tick();

    // Reset asserted between clock edges in ACCESS clears every output at once.
    drive(1, 1, 8'h70, 32'h1212_1212, 4'hF, 3'd7, 0, 32'h0, 0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    tick();
    tick();
    #1;
    check("rst.pre_pen", 32'(bus.penable), 32'd1);
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 1, 32'h3333_3333, 0);
    preset_n = 1'b0;
    #1;
    check_all_zero("rst");
    tick();
    tick();
    preset_n = 1'b1;
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    check("rst.rel_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst.rel_rv", 32'(bus.rsp_valid), 32'd0);
    tick();
    #1;
    check("rst.no_rsp", 32'(bus.rsp_valid), 32'd0);
    drive(1, 0, 8'h60, 32'h0, 4'hF, 3'd0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    check("rst.rd_paddr", 32'(bus.paddr), 32'h60);
    check("rst.rd_pwrite", 32'(bus.pwrite), 32'd0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 1, 32'h600D_600D, 0);
    tick();
    drive(0, 0, 8'h00, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
    check("rst.rd_rv", 32'(bus.rsp_valid), 32'd1);
    check("rst.rd_rdata", bus.rsp_rdata, 32'h600D_600D);
    check("rst.rd_err", 32'(bus.rsp_err), 32'd0);
    check("rst.rd_to", 32'(bus.rsp_timeout), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_param.md
Name: apb_master_param

Overview:
Parametrised APB4 requester that turns a valid/ready command interface into APB SETUP/ACCESS transfers and returns a one-cycle response pulse. It generalises the team's fixed 4-bit address / 16-bit data APB master with configurable widths, byte strobes, pprot, pslverr capture, back-to-back transfers and a wait-state timeout. It sits between a local command source (test sequencer, CSR bridge) and a single APB completer.

Parameters:
ADDR_WIDTH, 8, width of cmd_addr/paddr
DATA_WIDTH, 32, width of data buses; must be a multiple of 8
TIMEOUT, 16, consecutive wait cycles (pready low in ACCESS) before abort; 0 disables the timeout
CNT_WIDTH, 8, width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT

Ports:
pclk  in  1  APB clock
preset_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the pclk edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  protection attributes
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data
pslverr  in  1  completer error
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for aborted transfers
rsp_err  out  1  pslverr sampled at completion, or timeout
rsp_timeout  out  1  transfer aborted by timeout

Behaviour:
- Reset is preset_n, asynchronous, active-low; clock is pclk. On reset every output is 0 and the state is IDLE. A transfer in progress when reset asserts is dropped with no response.
- States:
  - IDLE: psel=0, penable=0. Accept on cmd_valid, then go to SETUP.
  - SETUP: psel=1, penable=0, then go to ACCESS unconditionally.
  - ACCESS: psel=1, penable=1.
- Completion occurs in an ACCESS cycle with pready=1, or on timeout abort.
  - On completion with cmd_valid=1: the next command is accepted in the same cycle and the state goes to SETUP. The block never goes ACCESS to ACCESS.
  - On completion with cmd_valid=0: the state goes to IDLE.
  - Without completion: the state stays in ACCESS.
- cmd_ready = (state==IDLE) || (state==ACCESS && completion). It is combinational from state, pready and the wait counter; it never depends on cmd_valid.
- Command fields are latched into holding registers on acceptance.
  - paddr, pwrite, pwdata, pstrb and pprot are driven from the holding registers while psel=1 and stay stable from SETUP through the final ACCESS cycle.
  - While psel=0 these outputs are 0.
  - pstrb is forced to 0 for reads (APB4 rule).
- Wait counter:
  - Clears on entry to SETUP.
  - Increments each ACCESS cycle with pready=0.
  - Timeout: TIMEOUT!=0, pready=0 and counter==TIMEOUT-1. A transfer therefore aborts after exactly TIMEOUT wait cycles in ACCESS.
  - If pready=1 arrives in the same cycle as the timeout condition, the transfer is a normal completion, not an abort.
- Response:
  - Registered. rsp_valid=1 for exactly one cycle, on the cycle after completion.
  - rsp_rdata = prdata for a read with pready=1, else 0.
  - rsp_err = pslverr (pready=1) or 1 (timeout).
  - rsp_timeout = 1 only on abort.
  - pslverr and prdata are ignored outside the completion cycle.
  - rsp_rdata, rsp_err and rsp_timeout hold their values until the next rsp_valid.
  - There is no response backpressure: the consumer must accept every pulse.
- Throughput: back-to-back zero-wait transfers take 2 cycles each, and rsp_valid pulses every 2 cycles.
- cmd_valid deasserted before acceptance is legal; nothing is issued.

Test Plan:
- Write with zero wait states: cmd addr=0x10, wdata=0xA5A5_0001, strb=0xF, prot=3'b010 accepted in IDLE -> SETUP cycle psel=1, penable=0, paddr=0x10; ACCESS psel=penable=1; next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0; then IDLE.
- Read with 3 wait states: read addr=0x24, pready low for 3 ACCESS cycles, prdata=0xDEAD_BEEF with pready -> paddr and pwrite=0 stable throughout, pstrb=0, rsp_rdata=0xDEAD_BEEF one cycle after pready.
- pslverr: write with pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0; a following transfer with pslverr=0 reports rsp_err=0.
- Back-to-back: cmd_valid held high with 3 commands and no waits -> SETUP/ACCESS repeated with no IDLE between, cmd_ready high only in the ACCESS cycles, 3 rsp_valid pulses 2 cycles apart.
- Timeout: TIMEOUT=4, pready stuck low -> exactly 4 ACCESS cycles, then psel=0; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready rising on the 4th ACCESS cycle -> normal completion, rsp_timeout=0.
- Reset mid-transfer: preset_n low during ACCESS -> all outputs 0 asynchronously, no rsp_valid; after release, a new read completes normally.
